// File: rtl/sar_avg_fifo.sv
// SAR result averager feeding a small first-word fall-through FIFO.
// Averages 2^AVG_LOG2 conversions per word; drops words on overflow and sets a sticky flag.
module sar_avg_fifo #(
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     ena,
  input  logic [5:0]               din,
  input  logic                     din_vld,
  input  logic                     dout_rdy,
  input  logic                     clr_ovf,
  output logic [5:0]               dout,
  output logic                     dout_vld,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     ovf
);

  localparam int AW = 6 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam logic [CW-1:0] CMAX = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    avg;
  logic          push;

  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [5:0]    dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, wr;

  assign dout_vld = (fill_q != '0);
  assign full     = (fill_q == FW'(DEPTH));
  assign pop      = dout_vld & dout_rdy;
  assign wr       = push & (~full | pop);
  assign dout     = dout_q;
  assign fill     = fill_q;
  assign ovf      = ovf_q;

  // Accumulate samples; emit the truncated mean on the last one of a group.
  always_comb begin
    sum   = acc_q + AW'(din);
    avg   = 6'(sum >> AVG_LOG2);
    acc_d = acc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (!ena) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (din_vld) begin
      if (cnt_q == CMAX) begin
        acc_d = '0;
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // FIFO bookkeeping; the head register is reloaded from post-update state.
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wptr_q] = avg;
    wptr_d = wptr_q + PW'(wr);
    rptr_d = rptr_q + PW'(pop);
    fill_d = fill_q + FW'(wr) - FW'(pop);
    ovf_d  = (push & full & ~pop) | (ovf_q & ~clr_ovf);
    dout_d = dout_q;
    if (fill_d != '0) begin
      if (fill_q == FW'(pop)) dout_d = avg;
      else                    dout_d = mem_q[rptr_d];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: doc/sar_avg_fifo.md
SAR_AVG_FIFO -- requirements
Module: sar_avg_fifo

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of the number of conversions averaged per output word; legal range 0..3.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rest  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  accumulation enable; low discards the partial average.
REQ-006 din  input  6  conversion result taken from the SAR logic q output.
REQ-007 din_vld  input  1  one-cycle strobe; din holds a finished conversion.
REQ-008 dout_rdy  input  1  downstream ready; pop occurs when dout_vld and dout_rdy are both high.
REQ-009 clr_ovf  input  1  synchronous clear of the ovf flag.
REQ-010 dout  output  6  head-of-FIFO averaged result; first-word fall-through.
REQ-011 dout_vld  output  1  high when the FIFO is not empty.
REQ-012 fill  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 ovf  output  1  sticky flag; an averaged word was dropped because the FIFO was full.

Function
REQ-014 Internal accumulator width SHALL be 6+AVG_LOG2 bits; the sample counter SHALL be AVG_LOG2 bits wide; the accumulator SHALL never overflow.
REQ-015 On an edge with ena=1 and din_vld=1, the sample SHALL be added to the accumulator and the sample counter SHALL increment.
REQ-016 If that sample is number 2^AVG_LOG2 (counter at max): average = (acc+din) >> AVG_LOG2, truncated, not rounded; a push request SHALL issue on the same edge; accumulator and counter SHALL clear to 0.
REQ-017 With AVG_LOG2=0, every accepted sample SHALL be pushed unchanged.
REQ-018 With ena=0, din_vld SHALL be ignored; accumulator and counter SHALL clear to 0 on each edge; FIFO contents, fill and ovf SHALL be retained.
REQ-019 A pushed word SHALL appear on dout with dout_vld=1 in the cycle after the final-sample edge when the FIFO was empty; latency is 1 clock from the final din_vld.
REQ-020 dout SHALL hold the oldest unpopped entry; dout SHALL be don't-care-free, holding the last read value or 0 after reset, while dout_vld=0.
REQ-021 Pop SHALL advance the read pointer and decrement fill on the same edge; pop while empty SHALL have no effect.
REQ-022 Push while not full SHALL write at the write pointer and increment fill.
REQ-023 Push and pop on the same edge SHALL both take effect, fill unchanged; this SHALL hold when full, so no drop and no ovf.
REQ-024 Push while full without pop SHALL discard the word, leave the FIFO unchanged, and set ovf.
REQ-025 Pointers SHALL wrap modulo DEPTH; fill SHALL saturate neither below 0 nor above DEPTH by construction.
REQ-026 clr_ovf=1 SHALL clear ovf on the next edge; if an overflow drop occurs on that same edge, ovf SHALL remain 1 (set wins).
REQ-027 The next sample group SHALL start accumulating on the edge right after a push; back-to-back din_vld on consecutive cycles SHALL be accepted without loss.

Reset
REQ-028 rest=0 SHALL asynchronously force: accumulator=0, sample counter=0, read/write pointers=0, fill=0, dout=0, dout_vld=0, ovf=0.
REQ-029 Reset asserted mid-group SHALL discard the partial sum; reset asserted with FIFO entries SHALL discard all entries.
REQ-030 After rest deasserts, the first din_vld SHALL be counted as sample 1 of a new group.

Verification
REQ-031 AVG_LOG2=2, ena=1, din 10,11,12,13 with strobes, dout_rdy=0 -> one cycle after the 4th strobe dout=11, dout_vld=1, fill=1.
REQ-032 AVG_LOG2=2, din=63 x4 -> dout=63; din 0,0,0,3 -> dout=0 (truncation).
REQ-033 AVG_LOG2=0, DEPTH=4, dout_rdy=0, din 1..5 -> fill=4, ovf=1, then pops with dout_rdy=1 give 1,2,3,4 and ovf stays 1 until clr_ovf.
REQ-034 AVG_LOG2=0, FIFO full, push with dout_rdy=1 on the same edge -> fill stays 4, ovf=0, new word at tail.
REQ-035 AVG_LOG2=2, 2 samples, ena low 1 cycle, then 4 samples of 8 -> single output 8.
REQ-036 rest pulse low mid-group with 2 entries queued -> fill=0, dout_vld=0, ovf=0 immediately; next full group produces a correct average.
